// File: rtl/vga_pattern_gen.sv
// Test-pattern generator behind the sync/pixel-counter stage: colour bars, checker, grid, scrolling gradient.
// Two register stages from counters/flags to RGB, DE and delayed sync flags; pattern latched at frame start.
module vga_pattern_gen #(
  parameter int ACTIVE_VERTICAL   = 1080,
  parameter int ACTIVE_HORIZONTAL = 1920,
  parameter int COUNT_DEPTH       = 12,
  parameter int BAR_WIDTH         = 240,
  parameter int CHECK_LOG2        = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_VSync,
  input  logic                   i_HSync,
  input  logic [COUNT_DEPTH-1:0] i_Vcnt,
  input  logic [COUNT_DEPTH-1:0] i_Hcnt,
  input  logic [1:0]             i_mode,
  output logic [7:0]             o_R,
  output logic [7:0]             o_G,
  output logic [7:0]             o_B,
  output logic                   o_DE,
  output logic                   o_VSync,
  output logic                   o_HSync,
  output logic [7:0]             o_frame_cnt
);

  localparam logic [COUNT_DEPTH-1:0] H_LIMIT  = COUNT_DEPTH'(ACTIVE_HORIZONTAL);
  localparam logic [COUNT_DEPTH-1:0] V_LIMIT  = COUNT_DEPTH'(ACTIVE_VERTICAL);
  localparam logic [COUNT_DEPTH-1:0] BAR_LAST = COUNT_DEPTH'(BAR_WIDTH - 1);

  logic [1:0]             mode_q;
  logic [7:0]             frame_cnt_q;
  logic [COUNT_DEPTH-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]             bar_idx_q, bar_idx_d;

  logic       frame_start;
  logic [1:0] mode_eff;
  logic [7:0] fc_eff;
  logic       de;
  logic       in_range;

  logic       s1_de, s1_vs, s1_hs, s1_valid;
  logic [1:0] s1_mode;
  logic [2:0] s1_bar_idx;
  logic       s1_cell, s1_grid;
  logic [7:0] s1_scr_r, s1_scr_g, s1_fc;

  logic [7:0] r_d, g_d, b_d;

  // The new mode and frame count take effect on the frame-start pixel itself.
  assign frame_start = (i_Vcnt == '0) && (i_Hcnt == '0);
  assign mode_eff    = frame_start ? i_mode : mode_q;
  assign fc_eff      = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
  assign de          = i_VSync & i_HSync;
  assign in_range    = (i_Hcnt < H_LIMIT) && (i_Vcnt < V_LIMIT);

  always_comb begin
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (i_Hcnt != '0) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + COUNT_DEPTH'(1);
        bar_idx_d = bar_idx_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q      <= '0;
      frame_cnt_q <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
    end else begin
      mode_q      <= mode_eff;
      frame_cnt_q <= fc_eff;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_de      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_hs      <= 1'b0;
      s1_valid   <= 1'b0;
      s1_mode    <= '0;
      s1_bar_idx <= '0;
      s1_cell    <= 1'b0;
      s1_grid    <= 1'b0;
      s1_scr_r   <= '0;
      s1_scr_g   <= '0;
      s1_fc      <= '0;
    end else begin
      s1_de      <= de;
      s1_vs      <= i_VSync;
      s1_hs      <= i_HSync;
      s1_valid   <= de & in_range;
      s1_mode    <= mode_eff;
      s1_bar_idx <= bar_idx_d;
      s1_cell    <= i_Hcnt[CHECK_LOG2] ^ i_Vcnt[CHECK_LOG2];
      s1_grid    <= (i_Hcnt[CHECK_LOG2-1:0] == '0) || (i_Vcnt[CHECK_LOG2-1:0] == '0);
      s1_scr_r   <= i_Hcnt[7:0] + fc_eff;
      s1_scr_g   <= i_Vcnt[7:0];
      s1_fc      <= fc_eff;
    end
  end

  // Blanking and out-of-range pixels are black regardless of mode.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (s1_valid) begin
      case (s1_mode)
        2'd0: begin
          r_d = {8{~s1_bar_idx[1]}};
          g_d = {8{~s1_bar_idx[2]}};
          b_d = {8{~s1_bar_idx[0]}};
        end
        2'd1: begin
          r_d = {8{s1_cell}};
          g_d = {8{s1_cell}};
          b_d = {8{s1_cell}};
        end
        2'd2: begin
          r_d = s1_grid ? 8'hFF : 8'h00;
          g_d = s1_grid ? 8'hFF : 8'h00;
          b_d = s1_grid ? 8'hFF : 8'h40;
        end
        default: begin
          r_d = s1_scr_r;
          g_d = s1_scr_g;
          b_d = s1_scr_r ^ s1_scr_g;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_R         <= '0;
      o_G         <= '0;
      o_B         <= '0;
      o_DE        <= 1'b0;
      o_VSync     <= 1'b0;
      o_HSync     <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_R         <= r_d;
      o_G         <= g_d;
      o_B         <= b_d;
      o_DE        <= s1_de;
      o_VSync     <= s1_vs;
      o_HSync     <= s1_hs;
      o_frame_cnt <= s1_fc;
    end
  end

endmodule
